// File: rtl/line_buffer_ring.sv
// line_buffer_ring: N-way scanline buffer ring for the draw pipeline.
// Each buffer moves through FREE -> DRAW -> FULL -> DISP -> CLEAR -> FREE.
// A built-in clear engine wipes retired lines to bg_colour one word per cycle.
// Ports:
//   clk_draw, rst_draw            draw-domain clock, async active-high reset
//   bg_colour                     background colour for clears and blank DISP
//   flip_req / flip_ack           draw side hands over a finished line
//   draw_ready, draw_idx          a DRAW buffer is assigned, and which one
//   wr_addr, wr_we, wr_data       per-lane word writes into the DRAW buffer
//   scan_done / line_repeat       scan-out consumed a line / had nothing new
//   rd_en, rd_addr -> rd_data, rd_valid   1-cycle pixel read of DISP buffer
//   disp_idx                      buffer currently being displayed
module line_buffer_ring #(
    parameter int unsigned NBUF  = 3,
    parameter int unsigned LANES = 8,
    parameter int unsigned CW    = 9,
    parameter int unsigned WORDS = 64,
    localparam int unsigned AW   = $clog2(WORDS),
    localparam int unsigned PAW  = $clog2(WORDS * LANES),
    localparam int unsigned IW   = $clog2(NBUF)
) (
    input  logic                  clk_draw,
    input  logic                  rst_draw,
    input  logic [CW-1:0]         bg_colour,
    input  logic                  flip_req,
    output logic                  flip_ack,
    output logic                  draw_ready,
    input  logic [AW-1:0]         wr_addr,
    input  logic [LANES-1:0]      wr_we,
    input  logic [LANES*CW-1:0]   wr_data,
    input  logic                  scan_done,
    output logic                  line_repeat,
    input  logic                  rd_en,
    input  logic [PAW-1:0]        rd_addr,
    output logic [CW-1:0]         rd_data,
    output logic                  rd_valid,
    output logic [IW-1:0]         disp_idx,
    output logic [IW-1:0]         draw_idx
);

    localparam int unsigned LW = $clog2(LANES);
    localparam int unsigned QW = $clog2(NBUF + 1);

    typedef enum logic [2:0] {R_FREE, R_DISP, R_FULL, R_DRAW, R_CLEAR} role_e;
    typedef enum logic {C_IDLE, C_RUN} clr_state_e;

    role_e          role_q [NBUF];
    role_e          role_d [NBUF];
    logic [IW-1:0]  fifo_q [NBUF];
    logic [IW-1:0]  fifo_d [NBUF];
    logic [QW-1:0]  fcnt_q, fcnt_d;
    logic [IW-1:0]  disp_q, disp_d;
    logic [IW-1:0]  draw_q, draw_d;
    logic           rdy_q, rdy_d;
    logic           blank_q, blank_d;
    logic           ack_q, ack_d;
    logic           rep_q, rep_d;

    clr_state_e     clr_state_q, clr_state_d;
    logic [IW-1:0]  clr_idx_q, clr_idx_d;
    logic [AW-1:0]  clr_addr_q, clr_addr_d;
    logic           clr_we_c, clr_last_c;

    logic           rd_valid_q;
    logic [CW-1:0]  rd_data_q;

    logic           clear_any_c, free_any_c;
    logic [IW-1:0]  clear_pick_c, free_pick_c;

    logic [LANES-1:0] buf_we_c    [NBUF];
    logic [AW-1:0]    buf_waddr_c [NBUF];
    logic [CW-1:0]    buf_wdata_c [NBUF][LANES];

    logic [CW-1:0]    mem_q [NBUF][WORDS][LANES];

    // Lowest-index CLEAR and FREE buffers (descending scan so lowest wins)
    always_comb begin
        clear_any_c  = 1'b0;
        clear_pick_c = '0;
        free_any_c   = 1'b0;
        free_pick_c  = '0;
        for (int i = int'(NBUF) - 1; i >= 0; i--) begin
            if (role_q[i] == R_CLEAR) begin
                clear_any_c  = 1'b1;
                clear_pick_c = IW'(i);
            end
            if (role_q[i] == R_FREE) begin
                free_any_c  = 1'b1;
                free_pick_c = IW'(i);
            end
        end
    end

    // Clear engine: state register
    always_ff @(posedge clk_draw or posedge rst_draw) begin
        if (rst_draw) begin
            clr_state_q <= C_IDLE;
            clr_idx_q   <= '0;
            clr_addr_q  <= '0;
        end else begin
            clr_state_q <= clr_state_d;
            clr_idx_q   <= clr_idx_d;
            clr_addr_q  <= clr_addr_d;
        end
    end

    // Clear engine: next state
    always_comb begin
        clr_state_d = clr_state_q;
        clr_idx_d   = clr_idx_q;
        clr_addr_d  = clr_addr_q;
        case (clr_state_q)
            C_IDLE: begin
                if (clear_any_c) begin
                    clr_state_d = C_RUN;
                    clr_idx_d   = clear_pick_c;
                    clr_addr_d  = '0;
                end
            end
            C_RUN: begin
                clr_addr_d = clr_addr_q + AW'(1);
                if (clr_addr_q == AW'(WORDS - 1)) begin
                    clr_state_d = C_IDLE;
                end
            end
            default: clr_state_d = C_IDLE;
        endcase
    end

    // Clear engine: outputs
    always_comb begin
        clr_we_c   = (clr_state_q == C_RUN);
        clr_last_c = (clr_state_q == C_RUN) && (clr_addr_q == AW'(WORDS - 1));
    end

    // Role bookkeeping: scan_done acts on the queue as it stood before any
    // same-cycle flip, so a just-flipped line is never promoted immediately.
    always_comb begin
        for (int i = 0; i < int'(NBUF); i++) begin
            role_d[i] = role_q[i];
            fifo_d[i] = fifo_q[i];
        end
        fcnt_d  = fcnt_q;
        disp_d  = disp_q;
        draw_d  = draw_q;
        rdy_d   = rdy_q;
        blank_d = blank_q;
        ack_d   = 1'b0;
        rep_d   = 1'b0;

        if (scan_done) begin
            if (fcnt_q != '0) begin
                disp_d             = fifo_q[0];
                role_d[fifo_q[0]]  = R_DISP;
                role_d[disp_q]     = R_CLEAR;
                blank_d            = 1'b0;
                for (int i = 0; i < int'(NBUF) - 1; i++) begin
                    fifo_d[i] = fifo_q[i+1];
                end
                fcnt_d = fcnt_q - QW'(1);
            end else begin
                rep_d = 1'b1;
            end
        end

        if (flip_req && rdy_q) begin
            role_d[draw_q]       = R_FULL;
            fifo_d[IW'(fcnt_d)]  = draw_q;
            fcnt_d               = fcnt_d + QW'(1);
            rdy_d                = 1'b0;
            ack_d                = 1'b1;
        end

        if (clr_last_c) begin
            role_d[clr_idx_q] = R_FREE;
        end

        // rdy_q doubles as "a DRAW buffer exists"
        if (!rdy_q && free_any_c) begin
            role_d[free_pick_c] = R_DRAW;
            draw_d              = free_pick_c;
            rdy_d               = 1'b1;
        end
    end

    always_ff @(posedge clk_draw or posedge rst_draw) begin
        if (rst_draw) begin
            for (int i = 0; i < int'(NBUF); i++) begin
                role_q[i] <= (i == 0) ? R_DISP : R_CLEAR;
                fifo_q[i] <= '0;
            end
            fcnt_q  <= '0;
            disp_q  <= '0;
            draw_q  <= '0;
            rdy_q   <= 1'b0;
            blank_q <= 1'b1;
            ack_q   <= 1'b0;
            rep_q   <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NBUF); i++) begin
                role_q[i] <= role_d[i];
                fifo_q[i] <= fifo_d[i];
            end
            fcnt_q  <= fcnt_d;
            disp_q  <= disp_d;
            draw_q  <= draw_d;
            rdy_q   <= rdy_d;
            blank_q <= blank_d;
            ack_q   <= ack_d;
            rep_q   <= rep_d;
        end
    end

    // Per-buffer write port: clear engine and draw side never share a buffer
    always_comb begin
        for (int b = 0; b < int'(NBUF); b++) begin
            buf_we_c[b]    = '0;
            buf_waddr_c[b] = '0;
            for (int l = 0; l < int'(LANES); l++) begin
                buf_wdata_c[b][l] = '0;
            end
            if (clr_we_c && (clr_idx_q == IW'(b))) begin
                buf_we_c[b]    = '1;
                buf_waddr_c[b] = clr_addr_q;
                for (int l = 0; l < int'(LANES); l++) begin
                    buf_wdata_c[b][l] = bg_colour;
                end
            end else if (rdy_q && (draw_q == IW'(b))) begin
                buf_we_c[b]    = wr_we;
                buf_waddr_c[b] = wr_addr;
                for (int l = 0; l < int'(LANES); l++) begin
                    buf_wdata_c[b][l] = wr_data[l*CW +: CW];
                end
            end
        end
    end

    always_ff @(posedge clk_draw) begin
        for (int b = 0; b < int'(NBUF); b++) begin
            for (int l = 0; l < int'(LANES); l++) begin
                if (buf_we_c[b][l]) begin
                    mem_q[b][buf_waddr_c[b]][l] <= buf_wdata_c[b][l];
                end
            end
        end
    end

    // Pixel read; a blank DISP line reads as background
    always_ff @(posedge clk_draw or posedge rst_draw) begin
        if (rst_draw) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_data_q <= blank_q ? bg_colour
                                     : mem_q[disp_q][rd_addr[PAW-1:LW]][rd_addr[LW-1:0]];
            end
        end
    end

    assign flip_ack    = ack_q;
    assign draw_ready  = rdy_q;
    assign line_repeat = rep_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign disp_idx    = disp_q;
    assign draw_idx    = draw_q;

endmodule

// File: tb/tb_line_buffer_ring.sv
// Directed bench for line_buffer_ring with default parameters.
module tb_line_buffer_ring;

    localparam int unsigned NBUF  = 3;
    localparam int unsigned LANES = 8;
    localparam int unsigned CW    = 9;
    localparam int unsigned WORDS = 64;
    localparam int unsigned AW    = $clog2(WORDS);
    localparam int unsigned PAW   = $clog2(WORDS * LANES);
    localparam int unsigned IW    = $clog2(NBUF);

    logic                clk_draw = 1'b0;
    logic                rst_draw;
    logic [CW-1:0]       bg_colour;
    logic                flip_req;
    logic                flip_ack;
    logic                draw_ready;
    logic [AW-1:0]       wr_addr;
    logic [LANES-1:0]    wr_we;
    logic [LANES*CW-1:0] wr_data;
    logic                scan_done;
    logic                line_repeat;
    logic                rd_en;
    logic [PAW-1:0]      rd_addr;
    logic [CW-1:0]       rd_data;
    logic                rd_valid;
    logic [IW-1:0]       disp_idx;
    logic [IW-1:0]       draw_idx;

    int n_checks = 0;
    int n_fail   = 0;

    line_buffer_ring #(.NBUF(NBUF), .LANES(LANES), .CW(CW), .WORDS(WORDS)) dut (
        .clk_draw    (clk_draw),
        .rst_draw    (rst_draw),
        .bg_colour   (bg_colour),
        .flip_req    (flip_req),
        .flip_ack    (flip_ack),
        .draw_ready  (draw_ready),
        .wr_addr     (wr_addr),
        .wr_we       (wr_we),
        .wr_data     (wr_data),
        .scan_done   (scan_done),
        .line_repeat (line_repeat),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .disp_idx    (disp_idx),
        .draw_idx    (draw_idx)
    );

    always #5 clk_draw = ~clk_draw;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one active edge, then settle before sampling/driving
    task automatic tick();
        @(posedge clk_draw);
        #1;
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (draw_ready !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check("wait_draw_ready", 32'(draw_ready), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_flip_ack"},    32'(flip_ack),    32'd0);
        check({tag, "_draw_ready"},  32'(draw_ready),  32'd0);
        check({tag, "_line_repeat"}, 32'(line_repeat), 32'd0);
        check({tag, "_rd_valid"},    32'(rd_valid),    32'd0);
        check({tag, "_rd_data"},     32'(rd_data),     32'd0);
        check({tag, "_disp_idx"},    32'(disp_idx),    32'd0);
        check({tag, "_draw_idx"},    32'(draw_idx),    32'd0);
    endtask

    initial begin
        rst_draw  = 1'b1;
        bg_colour = 9'h1A5;
        flip_req  = 1'b0;
        wr_addr   = '0;
        wr_we     = '0;
        wr_data   = '0;
        scan_done = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = '0;
        tick();
        tick();
        check_all_zero("reset");

        // Release reset and issue a read of the blank DISP line
        rst_draw = 1'b0;
        rd_en    = 1'b1;
        rd_addr  = PAW'(5);
        tick();                                   // edge 1
        check("blank_rd_valid", 32'(rd_valid), 32'd1);
        check("blank_rd_data",  32'(rd_data),  32'h1A5);
        rd_en = 1'b0;
        tick();                                   // edge 2
        check("rd_valid_drop", 32'(rd_valid), 32'd0);
        check("rd_data_hold",  32'(rd_data),  32'h1A5);
        repeat (63) tick();                       // edge 65: final clear write
        check("ready_before_clear_done", 32'(draw_ready), 32'd0);
        tick();                                   // edge 66
        check("ready_after_clear", 32'(draw_ready), 32'd1);
        check("draw_idx_first",    32'(draw_idx),   32'd1);

        // Full-word write into buffer 1 with the flip in the same cycle
        wr_addr = AW'(3);
        wr_we   = 8'hFF;
        for (int i = 0; i < int'(LANES); i++) wr_data[i*CW +: CW] = CW'(i + 1);
        flip_req = 1'b1;
        tick();
        check("flip_ack_pulse",   32'(flip_ack),   32'd1);
        check("flip_ready_drop",  32'(draw_ready), 32'd0);
        flip_req = 1'b0;
        wr_we    = '0;
        tick();
        check("flip_ack_single",  32'(flip_ack),   32'd0);

        // Flip without a DRAW buffer is ignored
        flip_req = 1'b1;
        tick();
        check("flip_ignored_ack", 32'(flip_ack), 32'd0);
        flip_req = 1'b0;

        // scan_done promotes buffer 1; same-cycle read still sees blank buffer 0
        scan_done = 1'b1;
        rd_en     = 1'b1;
        rd_addr   = PAW'(24);
        tick();
        check("promote_disp_idx", 32'(disp_idx),    32'd1);
        check("promote_no_rep",   32'(line_repeat), 32'd0);
        check("same_cycle_read",  32'(rd_data),     32'h1A5);
        scan_done = 1'b0;
        for (int i = 0; i < int'(LANES); i++) begin
            rd_addr = PAW'(24 + i);
            tick();
            check($sformatf("word3_lane%0d", i), 32'(rd_data), 32'(i + 1));
        end
        rd_en = 1'b0;

        // Empty queue: the second flip was dropped, so this repeats the line
        scan_done = 1'b1;
        tick();
        check("repeat_pulse",     32'(line_repeat), 32'd1);
        check("repeat_disp_keep", 32'(disp_idx),    32'd1);
        scan_done = 1'b0;
        tick();
        check("repeat_single",    32'(line_repeat), 32'd0);

        // Buffer 2 becomes DRAW once its clear completes
        wait_ready(200);
        check("draw_idx_second", 32'(draw_idx), 32'd2);
        wr_addr = AW'(7);
        wr_we   = 8'b0000_0100;
        wr_data = '0;
        wr_data[2*CW +: CW] = 9'h123;
        tick();
        wr_we    = '0;
        flip_req = 1'b1;
        tick();
        check("flip2_ack", 32'(flip_ack), 32'd1);
        flip_req = 1'b0;

        // Buffer 0 (retired earlier) becomes DRAW after its clear
        wait_ready(200);
        check("draw_idx_third", 32'(draw_idx), 32'd0);
        wr_addr = AW'(0);
        wr_we   = 8'b0000_0010;
        wr_data = '0;
        wr_data[1*CW +: CW] = 9'h0F0;
        tick();
        wr_we = '0;

        // Simultaneous scan_done and flip: buffer 2 shown, buffer 0 queued
        scan_done = 1'b1;
        flip_req  = 1'b1;
        tick();
        check("simul_disp_idx",   32'(disp_idx),    32'd2);
        check("simul_flip_ack",   32'(flip_ack),    32'd1);
        check("simul_ready_drop", 32'(draw_ready),  32'd0);
        check("simul_no_rep",     32'(line_repeat), 32'd0);
        scan_done = 1'b0;
        flip_req  = 1'b0;
        rd_en     = 1'b1;
        rd_addr   = PAW'(58);
        tick();
        check("buf2_written", 32'(rd_data), 32'h123);
        rd_addr = PAW'(59);
        tick();
        check("buf2_cleared", 32'(rd_data), 32'h1A5);
        rd_en = 1'b0;

        // Rotate buffer 0 in; memory keeps the old clear colour
        bg_colour = 9'h055;
        scan_done = 1'b1;
        tick();
        check("rot_disp_idx", 32'(disp_idx), 32'd0);
        scan_done = 1'b0;
        rd_en     = 1'b1;
        rd_addr   = PAW'(1);
        tick();
        check("buf0_written", 32'(rd_data), 32'h0F0);
        rd_addr = PAW'(40);
        tick();
        check("buf0_cleared", 32'(rd_data), 32'h1A5);
        check("pre_reset_valid", 32'(rd_valid), 32'd1);

        // Asynchronous reset while buffer 1 is mid-clear
        rd_en    = 1'b0;
        rst_draw = 1'b1;
        #1;
        check_all_zero("async_reset");
        tick();
        rst_draw = 1'b0;
        repeat (65) tick();
        check("rerst_ready_before", 32'(draw_ready), 32'd0);
        tick();
        check("rerst_ready_after",  32'(draw_ready), 32'd1);
        check("rerst_draw_idx",     32'(draw_idx),   32'd1);
        check("rerst_disp_idx",     32'(disp_idx),   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
